// File: rtl/pht_update_sched_pkg.sv
// Shared definitions for the pattern-history table update scheduler:
// FSM encoding, 2-bit counter constants and the saturating update.
package pht_update_sched_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [1:0] CTR_INIT = 2'b01;
   localparam logic [1:0] CTR_MAX  = 2'b11;
   localparam logic [1:0] CTR_MIN  = 2'b00;

   function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic inc);
      if (inc) return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
      return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
   endfunction

endpackage

// File: rtl/pht_update_sched_if.sv
// Update, lookup and status bundle between the pipeline and the PHT scheduler.
interface pht_update_sched_if #(
   parameter int INDEX_W = 10
);
   logic               clear_req_i;
   logic               a_valid_i, b_valid_i;
   logic [INDEX_W-1:0] a_index_i, b_index_i;
   logic               a_dir_i, b_dir_i;
   logic [INDEX_W-1:0] a_rd_index_i, b_rd_index_i;
   logic [1:0]         a_rd_ctr_o, b_rd_ctr_o;
   logic               busy_o, stall_o, overflow_o;

   modport master (
      output clear_req_i, a_valid_i, b_valid_i, a_index_i, b_index_i,
             a_dir_i, b_dir_i, a_rd_index_i, b_rd_index_i,
      input  a_rd_ctr_o, b_rd_ctr_o, busy_o, stall_o, overflow_o
   );

   modport slave (
      input  clear_req_i, a_valid_i, b_valid_i, a_index_i, b_index_i,
             a_dir_i, b_dir_i, a_rd_index_i, b_rd_index_i,
      output a_rd_ctr_o, b_rd_ctr_o, busy_o, stall_o, overflow_o
   );
endinterface

// File: rtl/pht_update_sched_fifo.sv
// Per-requester update queue. A push into a full queue is refused even when
// a pop happens in the same cycle; flush empties it synchronously.
module pht_req_fifo #(
   parameter int QDEPTH = 4,
   parameter int DW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] head_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(QDEPTH);

   logic [DW-1:0] mem_q [QDEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(QDEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rp_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      if (flush_i) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= din_i;
   end
endmodule

// File: rtl/pht_update_sched.sv
// Shared PHT owner: sweeps the table to weakly-not-taken, then round-robins
// queued M-stage updates from the predictor and chooser onto one RMW port.
module pht_update_sched
   import pht_update_sched_pkg::*;
#(
   parameter int INDEX_W = 10,
   parameter int QDEPTH  = 4
) (
   input logic              clk,
   input logic              rst,
   pht_update_sched_if.slave bus
);
   localparam int AW = INDEX_W + 1;
   localparam int NE = 1 << AW;

   state_e         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic           rr_q, rr_d;      // 0: A owns the tie, 1: B owns it
   logic           ovf_q, ovf_d;
   logic [1:0]     tbl_q [NE];

   logic           run, flush, push_a, push_b, grant_a, grant_b;
   logic [INDEX_W:0] a_head, b_head;
   logic           a_full, a_empty, b_full, b_empty;
   logic [AW-1:0]  g_addr, wr_addr;
   logic           g_dir, wr_en;
   logic [1:0]     wr_data;

   assign run    = (state_q == ST_RUN);
   assign flush  = ~run | bus.clear_req_i;
   assign push_a = run & bus.a_valid_i;
   assign push_b = run & bus.b_valid_i;

   pht_req_fifo #(.QDEPTH(QDEPTH), .DW(INDEX_W+1)) u_fifo_a (
      .clk(clk), .rst(rst), .flush_i(flush), .push_i(push_a), .pop_i(grant_a),
      .din_i({bus.a_index_i, bus.a_dir_i}), .head_o(a_head),
      .full_o(a_full), .empty_o(a_empty)
   );

   pht_req_fifo #(.QDEPTH(QDEPTH), .DW(INDEX_W+1)) u_fifo_b (
      .clk(clk), .rst(rst), .flush_i(flush), .push_i(push_b), .pop_i(grant_b),
      .din_i({bus.b_index_i, bus.b_dir_i}), .head_o(b_head),
      .full_o(b_full), .empty_o(b_empty)
   );

   assign grant_a = run & ~a_empty & (b_empty | ~rr_q);
   assign grant_b = run & ~b_empty & ~grant_a;
   assign g_addr  = grant_a ? {1'b0, a_head[INDEX_W:1]} : {1'b1, b_head[INDEX_W:1]};
   assign g_dir   = grant_a ? a_head[0] : b_head[0];

   // Single write port: sweep writes in INIT, granted RMW in RUN.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr_q;
      wr_data = CTR_INIT;
      if (!run) begin
         wr_en = 1'b1;
      end else if (grant_a | grant_b) begin
         wr_en   = 1'b1;
         wr_addr = g_addr;
         wr_data = ctr_sat(tbl_q[g_addr], g_dir);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_en) tbl_q[wr_addr] <= wr_data;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rr_d    = rr_q;
      ovf_d   = ovf_q | (push_a & a_full) | (push_b & b_full);
      case (state_q)
         ST_INIT: begin
            if (bus.clear_req_i) begin
               addr_d = '0;
            end else if (&addr_q) begin
               state_d = ST_RUN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (grant_a | grant_b) rr_d = grant_a;
            if (bus.clear_req_i) begin
               state_d = ST_INIT;
               addr_d  = '0;
               rr_d    = 1'b0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_INIT;
         addr_q  <= '0;
         rr_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rr_q    <= rr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy_o     = ~run;
   assign bus.stall_o    = ~run | a_full | b_full;
   assign bus.overflow_o = ovf_q;
   assign bus.a_rd_ctr_o = run ? tbl_q[{1'b0, bus.a_rd_index_i}] : CTR_INIT;
   assign bus.b_rd_ctr_o = run ? tbl_q[{1'b1, bus.b_rd_index_i}] : CTR_INIT;
endmodule

// File: tb/tb_pht_update_sched.sv
// Random + directed bench for pht_update_sched; a queue-based reference model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_pht_update_sched;
   localparam int IW = 3;
   localparam int QD = 2;
   localparam int NE = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pht_update_sched_if #(.INDEX_W(IW)) bus ();
   pht_update_sched #(.INDEX_W(IW), .QDEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic       busy, stall, ovf;
      logic [1:0] ard, brd;
   } exp_t;
   exp_t expq[$];

   // reference model state
   int tbl[NE];
   int qa[$], qb[$];
   bit m_busy, m_rr, m_ovf, m_live;
   int m_pos;
   int n_cmp = 0, n_bad = 0;

   function automatic void apply_upd(int e, int bank);
      int addr;
      addr = bank + e / 2;
      if (e % 2 == 1) tbl[addr] = (tbl[addr] >= 3) ? 3 : tbl[addr] + 1;
      else            tbl[addr] = (tbl[addr] <= 0) ? 0 : tbl[addr] - 1;
   endfunction

   function automatic void model_step(bit r, bit clr, bit av, int ai, bit ad,
                                      bit bv, int bi, bit bd);
      int sa, sb, e;
      if (!r) begin
         m_busy = 1; m_pos = 0; qa.delete(); qb.delete();
         m_rr = 0; m_ovf = 0; m_live = 1;
         return;
      end
      if (!m_live) return;
      if (m_busy) begin
         tbl[m_pos] = 1;
         if (clr) m_pos = 0;
         else if (m_pos == NE - 1) begin m_busy = 0; m_pos = 0; end
         else m_pos++;
         return;
      end
      sa = qa.size(); sb = qb.size();
      if (sa > 0 && (sb == 0 || m_rr == 0)) begin
         e = qa.pop_front(); apply_upd(e, 0); m_rr = 1;
      end else if (sb > 0) begin
         e = qb.pop_front(); apply_upd(e, NE / 2); m_rr = 0;
      end
      if (av) begin if (sa == QD) m_ovf = 1; else qa.push_back(ai * 2 + int'(ad)); end
      if (bv) begin if (sb == QD) m_ovf = 1; else qb.push_back(bi * 2 + int'(bd)); end
      if (clr) begin
         m_busy = 1; m_pos = 0; qa.delete(); qb.delete(); m_rr = 0;
      end
   endfunction

   function automatic exp_t model_out(int ar, int br);
      exp_t x;
      x.busy  = m_busy;
      x.stall = m_busy || qa.size() == QD || qb.size() == QD;
      x.ovf   = m_ovf;
      x.ard   = m_busy ? 2'd1 : 2'(tbl[ar]);
      x.brd   = m_busy ? 2'd1 : 2'(tbl[NE / 2 + br]);
      return x;
   endfunction

   task automatic drive(bit r, bit clr, bit av, int ai, bit ad, bit bv, int bi, bit bd,
                        int ar, int br);
      rst              = r;
      bus.clear_req_i  = clr;
      bus.a_valid_i    = av;
      bus.a_index_i    = IW'(ai);
      bus.a_dir_i      = ad;
      bus.b_valid_i    = bv;
      bus.b_index_i    = IW'(bi);
      bus.b_dir_i      = bd;
      bus.a_rd_index_i = IW'(ar);
      bus.b_rd_index_i = IW'(br);
      if (m_live) expq.push_back(model_out(ar, br));
      @(posedge clk);
      model_step(r, clr, av, ai, ad, bv, bi, bd);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, i % 8, (i + 3) % 8);
   endtask

   task automatic chk(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t x;
      if (expq.size() > 0) begin
         x = expq.pop_front();
         chk("busy_o",     int'(bus.busy_o),     int'(x.busy));
         chk("stall_o",    int'(bus.stall_o),    int'(x.stall));
         chk("overflow_o", int'(bus.overflow_o), int'(x.ovf));
         chk("a_rd_ctr_o", int'(bus.a_rd_ctr_o), int'(x.ard));
         chk("b_rd_ctr_o", int'(bus.b_rd_ctr_o), int'(x.brd));
      end
   end

   initial begin
      for (int i = 0; i < NE; i++) tbl[i] = 1;
      m_live = 0;
      // reset, full sweep, read every entry
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(26);
      // saturating increment then decrement of A[5]
      for (int i = 0; i < 3; i++) drive(1, 0, 1, 5, 1, 0, 0, 0, 5, 5);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 5, 0, 0, 0, 0, 5, 5);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 5, 5);
      // contended same-index updates in both banks
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 1, 1, 1, 1, 1, 1);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // hammer B while A keeps the arbiter busy: overflow
      for (int i = 0; i < 4; i++) drive(1, 0, 1, i, 1, 1, 2, 1, i, 2);
      idle(8);
      // clear with updates queued
      drive(1, 0, 1, 6, 1, 1, 6, 1, 6, 6);
      drive(1, 0, 1, 6, 1, 1, 6, 1, 6, 6);
      drive(1, 1, 1, 6, 1, 1, 6, 1, 6, 6);
      idle(22);
      // reset mid-RUN with updates queued
      drive(1, 0, 1, 7, 1, 1, 7, 0, 7, 7);
      drive(1, 0, 1, 7, 1, 1, 7, 0, 7, 7);
      drive(0, 0, 1, 7, 1, 1, 7, 0, 7, 7);
      idle(22);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(255, 0) != 0), ($urandom_range(63, 0) == 0),
               bit'($urandom_range(1, 0)), int'($urandom_range(7, 0)), bit'($urandom_range(1, 0)),
               bit'($urandom_range(1, 0)), int'($urandom_range(7, 0)), bit'($urandom_range(1, 0)),
               int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
      end
      idle(2);
      @(negedge clk);
      #1;
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
